// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES row-stage types and byte-rotation helpers, used by
//               both the forward shift_row and the inverse inv_shift_row stage.
// Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

  localparam int ROW_W = 32;

  // Four rows of the AES state, row 0 in the most significant position
  typedef struct packed {
    logic [ROW_W-1:0] r0;
    logic [ROW_W-1:0] r1;
    logic [ROW_W-1:0] r2;
    logic [ROW_W-1:0] r3;
  } aes_rows_t;

  // Occupancy-encoded buffer state: the encoding doubles as the beat count
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  function automatic logic [ROW_W-1:0] rot_row_r8(input logic [ROW_W-1:0] row);
    return {row[7:0], row[31:8]};
  endfunction

  function automatic logic [ROW_W-1:0] rot_row_16(input logic [ROW_W-1:0] row);
    return {row[15:0], row[31:16]};
  endfunction

  function automatic logic [ROW_W-1:0] rot_row_l8(input logic [ROW_W-1:0] row);
    return {row[23:0], row[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/inv_shift_row_if.sv
`default_nettype none
// ============================================================================
// Module      : inv_shift_row_if
// Description : Valid/ready stream bundle of the InvShiftRows stage: input
//               rows and tag, output rows and tag, flush and occupancy.
// Revision    : 1.0  initial release
// ============================================================================
interface inv_shift_row_if #(
  parameter int TAG_W = 4
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      SR1;
  logic [31:0]      SR2;
  logic [31:0]      SR3;
  logic [31:0]      SR4;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      ISR1;
  logic [31:0]      ISR2;
  logic [31:0]      ISR3;
  logic [31:0]      ISR4;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       occupancy;

  // Upstream/downstream environment view
  modport master (
    output flush, in_valid, SR1, SR2, SR3, SR4, in_tag, out_ready,
    input  in_ready, out_valid, ISR1, ISR2, ISR3, ISR4, out_tag, occupancy
  );

  // Stage view
  modport slave (
    input  flush, in_valid, SR1, SR2, SR3, SR4, in_tag, out_ready,
    output in_ready, out_valid, ISR1, ISR2, ISR3, ISR4, out_tag, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/skid_buffer2.sv
`default_nettype none
// ============================================================================
// Module      : skid_buffer2
// Description : Generic 2-entry valid/ready buffer (main + skid) with
//               synchronous flush, occupancy count and a ready that depends
//               only on registered state and flush.
// Revision    : 1.0  initial release
// ============================================================================
module skid_buffer2
  import aes_pkg::*;
#(
  parameter int WIDTH = 132
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             flush,
  input  wire logic             in_valid,
  output logic                  in_ready,
  input  wire logic [WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  wire logic             out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [1:0]            occupancy
);

  buf_state_t       state;
  logic             main_valid;
  logic             skid_valid;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             in_fire;
  logic             out_fire;

  // Ready comes from the skid flag only, so downstream ready never reaches upstream
  assign in_ready  = reset_n & ~skid_valid & ~flush;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid & out_ready;

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = state;

  // Buffer state machine: flush overrides every transition; skid drains into main
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= BUF_EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      state      <= BUF_EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (in_fire) begin
            main_data  <= in_data;
            main_valid <= 1'b1;
            state      <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (in_fire && out_fire) begin
            main_data <= in_data;
          end else if (in_fire) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
            state      <= BUF_FULL;
          end else if (out_fire) begin
            main_valid <= 1'b0;
            state      <= BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (out_fire) begin
            main_data  <= skid_data;
            skid_valid <= 1'b0;
            state      <= BUF_ONE;
          end
        end
        default: begin
          state      <= BUF_EMPTY;
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/inv_shift_row.sv
`default_nettype none
// ============================================================================
// Module      : inv_shift_row
// Description : AES decryption InvShiftRows stage. Rows are un-rotated on the
//               way in, so the 2-entry buffer stores transformed state and the
//               main entry drives the registered outputs.
// Revision    : 1.0  initial release
// ============================================================================
module inv_shift_row
  import aes_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  wire logic      clk,
  input  wire logic      reset_n,
  inv_shift_row_if.slave bus
);

  localparam int DATA_W = 4 * ROW_W + TAG_W;

  aes_rows_t         in_rows;
  aes_rows_t         out_rows;
  logic [TAG_W-1:0]  out_tag_int;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] out_data;

  // Undo the forward rotation of each row before storage
  always_comb begin
    in_rows.r0 = bus.SR1;
    in_rows.r1 = rot_row_r8(bus.SR2);
    in_rows.r2 = rot_row_16(bus.SR3);
    in_rows.r3 = rot_row_l8(bus.SR4);
  end

  // Tag rides in the same word as the state so the two can never separate
  assign in_data = {in_rows, bus.in_tag};

  skid_buffer2 #(
    .WIDTH (DATA_W)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_data),
    .occupancy (bus.occupancy)
  );

  assign {out_rows, out_tag_int} = out_data;
  assign bus.ISR1    = out_rows.r0;
  assign bus.ISR2    = out_rows.r1;
  assign bus.ISR3    = out_rows.r2;
  assign bus.ISR4    = out_rows.r3;
  assign bus.out_tag = out_tag_int;

endmodule
`default_nettype wire
